// File: rtl/ca_signal_gen.sv
// ca_signal_gen: GPS L1 C/A Gold-code generator clocked by a chip NCO and BPSK-modulated by buffered nav bits.
module ca_signal_gen #(
    parameter int NCO_WIDTH   = 24,
    parameter int DATA_EPOCHS = 20
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [4:0]           i_sat,
    input  logic [NCO_WIDTH-1:0] i_code_freq,
    input  logic                 i_data_in,
    input  logic                 i_data_valid,
    output logic                 o_data_ready,
    output logic                 o_ca_code,
    output logic                 o_tx_sym,
    output logic                 o_chip_tick,
    output logic                 o_epoch,
    output logic                 o_bit_edge,
    output logic [9:0]           o_chip_cnt,
    output logic                 o_underrun,
    output logic                 o_running
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t               r_state, w_state_nxt;
    logic [4:0]           r_sat;
    logic [NCO_WIDTH-1:0] r_acc;
    logic [NCO_WIDTH:0]   w_sum;
    logic [9:0]           r_chip, r_g1, r_g2;
    logic [5:0]           r_ep;
    logic [7:0]           w_taps;
    logic                 r_cur, r_hold, r_full, r_ready, r_tick, r_epoch, r_bit_edge, r_underrun;
    logic                 w_go, w_adv, w_tick, w_wrap, w_bound, w_fill, w_consume, w_full_nxt, w_ca;

    always_comb begin
        w_state_nxt = r_state;
        if (i_stop) w_state_nxt = IDLE;
        else if (i_start) w_state_nxt = RUN;
    end

    assign w_go       = (r_state == IDLE) && (w_state_nxt == RUN);
    assign w_adv      = (r_state == RUN) && (w_state_nxt == RUN);
    assign w_sum      = {1'b0, r_acc} + {1'b0, i_code_freq};
    assign w_tick     = w_adv && w_sum[NCO_WIDTH];
    assign w_wrap     = w_tick && (r_chip == 10'd1022);
    assign w_bound    = w_wrap && (r_ep == 6'(DATA_EPOCHS - 1));
    assign w_fill     = i_data_valid && r_ready;
    assign w_consume  = w_go || w_bound;
    assign w_full_nxt = w_fill || (r_full && !w_consume);

    // G2 phase-select taps, zero-based stage indices {tapA, tapB}
    always_comb begin
        w_taps = 8'h38;
        case (r_sat)
            5'd0:  w_taps = 8'h15;
            5'd1:  w_taps = 8'h26;
            5'd2:  w_taps = 8'h37;
            5'd3:  w_taps = 8'h48;
            5'd4:  w_taps = 8'h08;
            5'd5:  w_taps = 8'h19;
            5'd6:  w_taps = 8'h07;
            5'd7:  w_taps = 8'h18;
            5'd8:  w_taps = 8'h29;
            5'd9:  w_taps = 8'h12;
            5'd10: w_taps = 8'h23;
            5'd11: w_taps = 8'h45;
            5'd12: w_taps = 8'h56;
            5'd13: w_taps = 8'h67;
            5'd14: w_taps = 8'h78;
            5'd15: w_taps = 8'h89;
            5'd16: w_taps = 8'h03;
            5'd17: w_taps = 8'h14;
            5'd18: w_taps = 8'h25;
            5'd19: w_taps = 8'h36;
            5'd20: w_taps = 8'h47;
            5'd21: w_taps = 8'h58;
            5'd22: w_taps = 8'h02;
            5'd23: w_taps = 8'h35;
            5'd24: w_taps = 8'h46;
            5'd25: w_taps = 8'h57;
            5'd26: w_taps = 8'h68;
            5'd27: w_taps = 8'h79;
            5'd28: w_taps = 8'h05;
            5'd29: w_taps = 8'h16;
            5'd30: w_taps = 8'h27;
            default: w_taps = 8'h38;
        endcase
    end

    assign w_ca         = r_g1[9] ^ r_g2[w_taps[7:4]] ^ r_g2[w_taps[3:0]];
    assign o_running    = (r_state == RUN);
    assign o_ca_code    = o_running & w_ca;
    assign o_tx_sym     = o_running & (w_ca ^ r_cur);
    assign o_data_ready = r_ready;
    assign o_chip_tick  = r_tick;
    assign o_epoch      = r_epoch;
    assign o_bit_edge   = r_bit_edge;
    assign o_chip_cnt   = r_chip;
    assign o_underrun   = r_underrun;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_sat      <= '0;
            r_acc      <= '0;
            r_chip     <= '0;
            r_ep       <= '0;
            r_g1       <= '1;
            r_g2       <= '1;
            r_cur      <= 1'b0;
            r_hold     <= 1'b0;
            r_full     <= 1'b0;
            r_ready    <= 1'b0;
            r_tick     <= 1'b0;
            r_epoch    <= 1'b0;
            r_bit_edge <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick     <= w_tick;
            r_epoch    <= w_wrap;
            r_bit_edge <= w_bound;
            r_full     <= w_full_nxt;
            r_ready    <= !w_full_nxt;
            if (w_fill) r_hold <= i_data_in;
            if (w_consume) r_cur <= r_full & r_hold;
            if (w_go) r_underrun <= 1'b0;
            else if (w_bound && !r_full) r_underrun <= 1'b1;
            if (w_go) begin
                r_sat  <= i_sat;
                r_acc  <= '0;
                r_chip <= '0;
                r_ep   <= '0;
                r_g1   <= '1;
                r_g2   <= '1;
            end else if (w_adv) begin
                r_acc <= w_sum[NCO_WIDTH-1:0];
                if (w_tick) begin
                    r_chip <= w_wrap ? 10'd0 : r_chip + 10'd1;
                    r_g1   <= w_wrap ? 10'h3FF : {r_g1[8:0], r_g1[2] ^ r_g1[9]};
                    r_g2   <= w_wrap ? 10'h3FF : {r_g2[8:0], r_g2[1] ^ r_g2[2] ^ r_g2[5] ^ r_g2[7] ^ r_g2[8] ^ r_g2[9]};
                end
                if (w_wrap) r_ep <= w_bound ? 6'd0 : r_ep + 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_ca_signal_gen.sv
// tb_ca_signal_gen: directed checks of chip sequences, epoch/bit timing, data buffering, underrun and reset.
module tb_ca_signal_gen;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, data_in = 1'b0, data_valid = 1'b0;
    logic [4:0]  sat = 5'd0;
    logic [23:0] code_freq = 24'h800000;
    logic        o_data_ready, o_ca_code, o_tx_sym, o_chip_tick, o_epoch, o_bit_edge, o_underrun, o_running;
    logic [9:0]  o_chip_cnt;
    logic [17:0] all_out;
    int          n_cmp = 0, n_bad = 0;

    assign all_out = {o_data_ready, o_ca_code, o_tx_sym, o_chip_tick, o_epoch, o_bit_edge, o_chip_cnt, o_underrun, o_running};

    always #5 clk = ~clk;

    ca_signal_gen #(.NCO_WIDTH(24), .DATA_EPOCHS(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_sat(sat),
        .i_code_freq(code_freq), .i_data_in(data_in), .i_data_valid(data_valid),
        .o_data_ready(o_data_ready), .o_ca_code(o_ca_code), .o_tx_sym(o_tx_sym),
        .o_chip_tick(o_chip_tick), .o_epoch(o_epoch), .o_bit_edge(o_bit_edge),
        .o_chip_cnt(o_chip_cnt), .o_underrun(o_underrun), .o_running(o_running)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop;
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if (all_out !== 18'h0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        #5 rst_n = 1'b1;
        step();
        n_cmp++; if ({o_data_ready, o_running} !== 2'b10) begin n_bad++; $display("FAIL idle_ready: got %b want 10", {o_data_ready, o_running}); end
    endtask

    task automatic test_prn1;
        logic [9:0] w = '0;
        int bc = 0, bt = 0;
        sat = 5'd0;
        pulse_start();
        n_cmp++; if (o_running !== 1'b1) begin n_bad++; $display("FAIL prn1_running: got %b want 1", o_running); end
        for (int i = 0; i < 10; i++) begin
            w = {w[8:0], o_ca_code};
            if (o_chip_cnt !== 10'(i)) bc++;
            step();
            if (o_chip_tick !== 1'b0) bt++;
            step();
            if (o_chip_tick !== 1'b1) bt++;
        end
        n_cmp++; if (w !== 10'b1100100000) begin n_bad++; $display("FAIL prn1_chips: got %b want 1100100000", w); end
        n_cmp++; if (bc != 0) begin n_bad++; $display("FAIL prn1_chip_cnt: got %0d errors want 0", bc); end
        n_cmp++; if (bt != 0) begin n_bad++; $display("FAIL prn1_tick_rate: got %0d errors want 0", bt); end
        pulse_stop();
        n_cmp++; if ({o_running, o_ca_code, o_tx_sym, o_chip_tick} !== 4'b0) begin n_bad++; $display("FAIL stop_idle: got %b want 0000", {o_running, o_ca_code, o_tx_sym, o_chip_tick}); end
    endtask

    task automatic test_prn2_wrap;
        logic [9:0] w = '0, prev = '0, pc = '0, cz = '1;
        logic c0 = 1'b0;
        int e1 = -1, e2 = -1;
        sat = 5'd1;
        pulse_start();
        for (int n = 0; n < 4200; n++) begin
            if (n < 20 && n % 2 == 0) w = {w[8:0], o_ca_code};
            if (o_epoch) begin
                if (e1 < 0) begin e1 = n; pc = prev; cz = o_chip_cnt; c0 = o_ca_code; end
                else if (e2 < 0) e2 = n;
            end
            prev = o_chip_cnt;
            step();
        end
        n_cmp++; if (w !== 10'b1110010000) begin n_bad++; $display("FAIL prn2_chips: got %b want 1110010000", w); end
        n_cmp++; if (e1 != 2046) begin n_bad++; $display("FAIL first_epoch: got %0d want 2046", e1); end
        n_cmp++; if (e2 - e1 != 2046) begin n_bad++; $display("FAIL epoch_period: got %0d want 2046", e2 - e1); end
        n_cmp++; if ({pc, cz} !== {10'd1022, 10'd0}) begin n_bad++; $display("FAIL chip_wrap: got %0d->%0d want 1022->0", pc, cz); end
        n_cmp++; if (c0 !== 1'b1) begin n_bad++; $display("FAIL chip1024_eq_chip0: got %b want 1", c0); end
        pulse_stop();
    endtask

    task automatic test_data_and_underrun;
        int n, bad;
        data_in = 1'b1; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        n_cmp++; if (o_data_ready !== 1'b0) begin n_bad++; $display("FAIL preload_ready: got %b want 0", o_data_ready); end
        sat = 5'd0;
        pulse_start();
        n_cmp++; if ({o_data_ready, o_tx_sym ^ o_ca_code} !== 2'b11) begin n_bad++; $display("FAIL start_consume: got %b want 11", {o_data_ready, o_tx_sym ^ o_ca_code}); end
        data_in = 1'b0; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        n = 1; bad = 0;
        n_cmp++; if (o_data_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready: got %b want 0", o_data_ready); end
        while (!o_bit_edge && n < 5000) begin if (o_tx_sym !== ~o_ca_code) bad++; step(); n++; end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bit1_inverts: got %0d errors want 0", bad); end
        n_cmp++; if (n != 4092) begin n_bad++; $display("FAIL bit_edge1_time: got %0d want 4092", n); end
        n_cmp++; if ({o_tx_sym ^ o_ca_code, o_data_ready, o_underrun} !== 3'b010) begin n_bad++; $display("FAIL bit_edge1_state: got %b want 010", {o_tx_sym ^ o_ca_code, o_data_ready, o_underrun}); end
        data_in = 1'b1; data_valid = 1'b1;
        step(); n++;
        data_valid = 1'b0;
        bad = 0;
        while (!o_bit_edge && n < 9000) begin if (o_tx_sym !== o_ca_code) bad++; step(); n++; end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bit0_passes: got %0d errors want 0", bad); end
        n_cmp++; if (n != 8184) begin n_bad++; $display("FAIL bit_edge2_time: got %0d want 8184", n); end
        n_cmp++; if ({o_tx_sym ^ o_ca_code, o_underrun} !== 2'b10) begin n_bad++; $display("FAIL bit_edge2_state: got %b want 10", {o_tx_sym ^ o_ca_code, o_underrun}); end
        step(); n++;
        while (!o_bit_edge && n < 13000) begin step(); n++; end
        n_cmp++; if (n != 12276) begin n_bad++; $display("FAIL underrun_edge_time: got %0d want 12276", n); end
        n_cmp++; if ({o_tx_sym ^ o_ca_code, o_underrun} !== 2'b01) begin n_bad++; $display("FAIL underrun_set: got %b want 01", {o_tx_sym ^ o_ca_code, o_underrun}); end
        repeat (10) step();
        pulse_stop();
        n_cmp++; if ({o_underrun, o_running} !== 2'b10) begin n_bad++; $display("FAIL underrun_sticky: got %b want 10", {o_underrun, o_running}); end
        pulse_start();
        n_cmp++; if (o_underrun !== 1'b0) begin n_bad++; $display("FAIL underrun_clear: got %b want 0", o_underrun); end
    endtask

    task automatic test_simultaneous;
        int n = 0;
        while (n < 4091) begin step(); n++; end
        data_in = 1'b1; data_valid = 1'b1;
        step(); n++;
        data_valid = 1'b0;
        n_cmp++; if ({o_bit_edge, o_underrun, o_tx_sym ^ o_ca_code, o_data_ready} !== 4'b1100) begin n_bad++; $display("FAIL fill_on_boundary: got %b want 1100", {o_bit_edge, o_underrun, o_tx_sym ^ o_ca_code, o_data_ready}); end
        step(); n++;
        while (!o_bit_edge && n < 9000) begin step(); n++; end
        n_cmp++; if (n != 8184) begin n_bad++; $display("FAIL held_edge_time: got %0d want 8184", n); end
        n_cmp++; if ({o_tx_sym ^ o_ca_code, o_data_ready} !== 2'b11) begin n_bad++; $display("FAIL held_bit_used: got %b want 11", {o_tx_sym ^ o_ca_code, o_data_ready}); end
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        n_cmp++; if ({o_running, o_ca_code, o_chip_tick} !== 3'b000) begin n_bad++; $display("FAIL stop_start_run: got %b want 000", {o_running, o_ca_code, o_chip_tick}); end
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        n_cmp++; if (o_running !== 1'b0) begin n_bad++; $display("FAIL stop_start_idle: got %b want 0", o_running); end
    endtask

    task automatic test_async_reset;
        logic [9:0] w = '0;
        int bad = 0;
        sat = 5'd0;
        pulse_start();
        data_in = 1'b1; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        repeat (100) step();
        n_cmp++; if (o_chip_cnt !== 10'd50) begin n_bad++; $display("FAIL pre_reset_chip: got %0d want 50", o_chip_cnt); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (all_out !== 18'h0) begin n_bad++; $display("FAIL async_reset_outputs: got %h want 0", all_out); end
        #2 rst_n = 1'b1;
        step();
        n_cmp++; if ({o_data_ready, o_running} !== 2'b10) begin n_bad++; $display("FAIL held_bit_lost: got %b want 10", {o_data_ready, o_running}); end
        sat = 5'd1;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            w = {w[8:0], o_ca_code};
            if (o_tx_sym !== o_ca_code) bad++;
            step();
            step();
        end
        n_cmp++; if (w !== 10'b1110010000) begin n_bad++; $display("FAIL restart_chips: got %b want 1110010000", w); end
        n_cmp++; if ({bad != 0, o_underrun} !== 2'b00) begin n_bad++; $display("FAIL restart_data: got %0d errors underrun %b want 0 0", bad, o_underrun); end
    endtask

    initial begin
        test_reset();
        test_prn1();
        test_prn2_wrap();
        test_data_and_underrun();
        test_simultaneous();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ca_signal_gen.md
Name: ca_signal_gen

Overview:
- Transmit-side counterpart of the C/A code tracker. Synthesises a baseband GPS L1 C/A symbol stream for one selected satellite PRN.
- The 1023-chip Gold code is clocked by a phase-accumulator chip NCO and BPSK-modulated (XOR) with 50 bps-style navigation bits. Each bit spans DATA_EPOCHS code epochs.
- Nav bits are supplied through a valid/ready holding register.
- Used as an in-FPGA stimulus source for closed-loop testing of the receiver chain.

Parameters:
NCO_WIDTH, 24, chip NCO accumulator width
DATA_EPOCHS, 20, code epochs per navigation bit (2..63)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; leaves IDLE and begins generation with current sat
stop  in  1  1-cycle pulse; returns to IDLE
sat  in  5  PRN select, 0..31 maps to PRN 1..32; sampled only on accepted start
code_freq  in  NCO_WIDTH  accumulator increment per clk; chip rate = f_clk*code_freq/2^NCO_WIDTH
data_in  in  1  next navigation bit
data_valid  in  1  data_in is valid
data_ready  out  1  holding register empty; transfer occurs when valid&&ready
ca_code  out  1  current unmodulated C/A chip
tx_sym  out  1  ca_code XOR current nav bit
chip_tick  out  1  1-cycle pulse on each chip advance
epoch  out  1  1-cycle pulse when code wraps to chip 0
bit_edge  out  1  1-cycle pulse when a new nav bit starts
chip_cnt  out  10  current chip index 0..1022
underrun  out  1  sticky: a bit boundary found the holding register empty
running  out  1  high in RUN state

Behaviour:
- Reset (rst=0, asynchronous) puts the block in IDLE and clears every output to 0, including data_ready. G1 and G2 registers go to all ones.
- FSM has two states, IDLE and RUN.
- IDLE -> RUN on start. On that edge:
  - sat is latched; acc=0; chip_cnt=0; epoch_cnt=0.
  - G1=G2=10'h3FF.
  - cur_bit takes the holding register if it is full, else 0. A full holding register is emptied by this transfer.
  - underrun is cleared.
- RUN -> IDLE on stop. stop takes priority over start in the same cycle. In IDLE all pulses and tx_sym/ca_code are 0; data_ready=1.
- NCO: acc <= acc + code_freq each cycle in RUN, modulo 2^NCO_WIDTH. The carry out produces chip_tick in the same cycle the registers update. code_freq=0 freezes the code.
- Code generator:
  - G1 polynomial 1+x^3+x^10. G2 polynomial 1+x^2+x^3+x^6+x^8+x^9+x^10. Both shift on chip_tick.
  - ca_code = G1[10] ^ G2[tapA] ^ G2[tapB], with the IS-GPS-200 phase-select tap pairs (PRN1: 2,6; PRN2: 3,7; ... PRN32: 4,9).
  - The chip after the 1023rd tick is chip 0 again. chip_cnt wraps 1022->0 and G1/G2 are forced back to all ones on that tick.
- epoch is asserted on the chip_tick that wraps chip_cnt to 0. Each epoch increments epoch_cnt.
- Bit boundary: when epoch_cnt reaches DATA_EPOCHS-1 and an epoch occurs:
  - epoch_cnt <= 0 and bit_edge is pulsed.
  - cur_bit takes the holding register if full (emptying it). If empty, cur_bit <= 0 and underrun <= 1.
- Holding register: data_ready = RUN-or-IDLE && empty.
  - A valid&&ready cycle fills it.
  - If a fill and a boundary consume happen in the same cycle, the consume sees the old (empty) state. The new bit stays held for the next boundary.
- tx_sym = ca_code ^ cur_bit, updated coincident with ca_code and cur_bit changes. No extra pipeline stage: start-to-first-chip latency is 1 clk (outputs valid the cycle after start).
- start while in RUN is ignored. sat changes in RUN are ignored until the next start.
- Reset mid-operation aborts immediately. The held bit is lost and underrun is cleared.

Test Plan:
- PRN1 chip sequence: sat=0, code_freq=2^23, start -> chip_tick every 2 clk; first 10 ca_code chips 1100100000 (octal 1440).
- PRN2 and wrap: sat=1 -> first 10 chips 1110010000 (octal 1620). epoch pulses exactly 2046 clk apart. The 1024th chip equals chip 0. chip_cnt goes 1022->0.
- Data modulation: preload bit 1, then feed 0, 1 continuously; DATA_EPOCHS=20 -> bit_edge every 40920 clk. tx_sym = ~ca_code during bits of value 1. data_ready reasserts 1 clk after each consume.
- Underrun: withhold data_valid across a boundary -> cur_bit=0, underrun=1 and stays sticky until the next start.
- Simultaneous events: fill on the boundary cycle -> old empty state is used and underrun=1; the new bit appears at the following boundary. stop+start in the same cycle -> IDLE.
- Async reset: drop rst mid-epoch between clk edges -> all outputs 0 immediately. After release and start, PRN restarts at chip 0.
